// File: rtl/intr_ctrl.sv
// Interrupt controller: latches timer and external request edges, masks and
// prioritises them, and sequences a single non-nesting in-service level.
module intr_ctrl #(
  parameter int unsigned NSRC    = 4,
  parameter int unsigned TIMER_W = 32,
  parameter int unsigned CAUSE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSRC-1:0]    src_req,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  input  logic               icall_ack,
  input  logic               iret,
  output logic               irr,
  output logic [CAUSE_W-1:0] cause,
  output logic               in_service
);

  localparam int unsigned NS = NSRC + 1;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_PEND   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  logic [NSRC-1:0]    src_q;
  logic [NS-1:0]      pending;
  logic [NS-1:0]      mask;
  logic [TIMER_W-1:0] period;
  logic [TIMER_W-1:0] counter;
  logic               timer_en;

  logic [NS-1:0]      pending_n;
  logic [TIMER_W-1:0] counter_n;
  logic               fire;
  logic               timer_clr;
  logic               take;
  logic [NS-1:0]      active;
  logic [NS-1:0]      set_bits;
  logic [NS-1:0]      clr_bits;
  logic [CAUSE_W-1:0] top_id;
  logic               irr_n;
  logic [CAUSE_W-1:0] cause_n;
  logic               in_service_n;

  // Timer: a write to period or control restarts the count and suppresses a fire.
  always_comb begin
    counter_n = counter;
    fire      = 1'b0;
    timer_clr = cfg_we && (cfg_addr == ADDR_PERIOD || cfg_addr == ADDR_CTRL);
    if (timer_clr) begin
      counter_n = '0;
    end else if (timer_en && period != '0) begin
      if (counter == period - TIMER_W'(1)) begin
        counter_n = '0;
        fire      = 1'b1;
      end else begin
        counter_n = counter + TIMER_W'(1);
      end
    end
  end

  // Pending update: new edges win over W1C and acknowledge clears.
  always_comb begin
    take     = icall_ack && irr;
    set_bits = {src_req & ~src_q, fire};
    clr_bits = '0;
    if (cfg_we && cfg_addr == ADDR_PEND) clr_bits = cfg_wdata[NS-1:0];
    if (take) clr_bits = clr_bits | (NS'(1) << cause);
    pending_n = (pending & ~clr_bits) | set_bits;
  end

  // Fixed priority: lowest id wins.
  always_comb begin
    active = pending & mask;
    top_id = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (active[i]) top_id = CAUSE_W'(i);
    end
  end

  // Request, cause and in-service sequencing.
  always_comb begin
    irr_n        = (|active) && !in_service && !take;
    cause_n      = (in_service || take) ? cause : top_id;
    in_service_n = in_service;
    if (take) in_service_n = 1'b1;
    else if (iret && in_service) in_service_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q      <= '0;
      pending    <= '0;
      mask       <= '0;
      period     <= '0;
      counter    <= '0;
      timer_en   <= 1'b0;
      irr        <= 1'b0;
      cause      <= '0;
      in_service <= 1'b0;
    end else begin
      src_q      <= src_req;
      pending    <= pending_n;
      counter    <= counter_n;
      irr        <= irr_n;
      cause      <= cause_n;
      in_service <= in_service_n;
      if (cfg_we) begin
        case (cfg_addr)
          ADDR_MASK:   mask     <= cfg_wdata[NS-1:0];
          ADDR_PERIOD: period   <= cfg_wdata[TIMER_W-1:0];
          ADDR_CTRL:   timer_en <= cfg_wdata[0];
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK:   cfg_rdata = 32'(mask);
      ADDR_PERIOD: cfg_rdata = 32'(period);
      ADDR_PEND:   cfg_rdata = 32'(pending);
      ADDR_CTRL:   cfg_rdata = 32'({cause, in_service, timer_en});
      default:     cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model of the controller.
module tb_intr_ctrl;
  localparam int NSRC    = 4;
  localparam int TIMER_W = 32;
  localparam int CAUSE_W = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [NSRC-1:0]    src_req;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic [31:0]        cfg_rdata;
  logic               icall_ack;
  logic               iret;
  logic               irr;
  logic [CAUSE_W-1:0] cause;
  logic               in_service;

  always #5 clk = ~clk;

  intr_ctrl #(.NSRC(NSRC), .TIMER_W(TIMER_W), .CAUSE_W(CAUSE_W)) dut (
    .clk(clk), .reset(reset), .src_req(src_req), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .icall_ack(icall_ack), .iret(iret), .irr(irr), .cause(cause),
    .in_service(in_service)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference state: timer tracked as cycles elapsed since its last restart.
  int     m_pend, m_mask, m_en, m_irr, m_cause, m_ins, m_srcq;
  longint m_per, m_el;

  function automatic longint model_read(input int a);
    case (a)
      0:       return longint'(m_mask);
      1:       return m_per;
      2:       return longint'(m_pend);
      default: return longint'(m_cause * 4 + m_ins * 2 + m_en);
    endcase
  endfunction

  task automatic tick();
    int pend_n, mask_n, en_n, irr_n, cause_n, ins_n, srcq_n;
    int rise, fire, clr, act, take, w13;
    longint per_n, el_n;
    if (reset) begin
      {pend_n, mask_n, en_n, irr_n, cause_n, ins_n, srcq_n} = '0;
      per_n = 0; el_n = 0;
    end else begin
      w13   = (cfg_we && (cfg_addr == 2'd1 || cfg_addr == 2'd3)) ? 1 : 0;
      fire  = (!w13 && m_en != 0 && m_per != 0 && ((m_el + 1) % m_per) == 0) ? 1 : 0;
      el_n  = w13 ? 0 : (m_en != 0 && m_per != 0) ? m_el + 1 : m_el;
      rise  = int'(src_req) & ~m_srcq & 15;
      take  = (icall_ack && m_irr != 0) ? 1 : 0;
      clr   = (cfg_we && cfg_addr == 2'd2) ? int'(cfg_wdata & 32'h1F) : 0;
      if (take != 0) clr = clr | (1 << m_cause);
      pend_n = (m_pend & ~clr) | (rise * 2) | fire;
      act    = m_pend & m_mask;
      irr_n  = (act != 0 && m_ins == 0 && take == 0) ? 1 : 0;
      cause_n = m_cause;
      if (m_ins == 0 && take == 0) begin
        cause_n = 0;
        for (int i = 0; i < 5; i++) begin
          if (((act >> i) & 1) != 0) begin cause_n = i; break; end
        end
      end
      ins_n  = (take != 0) ? 1 : (iret && m_ins != 0) ? 0 : m_ins;
      mask_n = (cfg_we && cfg_addr == 2'd0) ? int'(cfg_wdata & 32'h1F) : m_mask;
      per_n  = (cfg_we && cfg_addr == 2'd1) ? longint'(cfg_wdata) : m_per;
      en_n   = (cfg_we && cfg_addr == 2'd3) ? int'(cfg_wdata[0]) : m_en;
      srcq_n = int'(src_req);
    end
    @(posedge clk);
    #1;
    m_pend = pend_n; m_mask = mask_n; m_en = en_n; m_irr = irr_n;
    m_cause = cause_n; m_ins = ins_n; m_srcq = srcq_n; m_per = per_n; m_el = el_n;
    check("irr", irr, m_irr);
    check("cause", cause, m_cause);
    check("in_service", in_service, m_ins);
    check("rdata", cfg_rdata, model_read(int'(cfg_addr)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_src(input logic [NSRC-1:0] v);
    src_req = v;
    tick();
    src_req = '0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input longint exp);
    cfg_addr = a;
    #1;
    check(tag, cfg_rdata, exp);
  endtask

  initial begin
    int lat;
    {m_pend, m_mask, m_en, m_irr, m_cause, m_ins, m_srcq} = '0;
    m_per = 0; m_el = 0;
    reset = 1'b1; src_req = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    icall_ack = 1'b0; iret = 1'b0;
    #1;
    idle(2);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) rd_check("reset_read", 2'(a), 0);
    check("reset_irr", irr, 0);

    // Single source, entry and exit.
    wr(2'd0, 32'h1F);
    pulse_src(4'b0010);
    rd_check("pend_id2", 2'd2, 'h04);
    tick();
    check("irr_id2", irr, 1);
    check("cause_id2", cause, 2);
    icall_ack = 1'b1; tick(); icall_ack = 1'b0;
    check("ack_ins", in_service, 1);
    check("ack_irr", irr, 0);
    rd_check("ack_pend", 2'd2, 0);
    iret = 1'b1; tick(); iret = 1'b0;
    check("iret_ins", in_service, 0);
    tick();
    check("iret_irr", irr, 0);

    // Two sources together: lower id first, the other re-raises after iret.
    pulse_src(4'b0101);
    tick();
    check("prio_cause", cause, 1);
    icall_ack = 1'b1; tick(); icall_ack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
    tick();
    check("rearm_irr", irr, 1);
    check("rearm_cause", cause, 3);
    icall_ack = 1'b1; tick(); icall_ack = 1'b0;
    iret = 1'b1; tick(); iret = 1'b0;
    tick();

    // Timer latency and stop.
    wr(2'd0, 32'h01);
    wr(2'd1, 32'd5);
    wr(2'd3, 32'd1);
    lat = 0;
    while (!irr && lat < 20) begin tick(); lat++; end
    check("timer_latency", lat, 6);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'h1F);
    idle(20);
    rd_check("timer_stopped", 2'd2, 0);

    // Masked source latches, unmask raises, W1C withdraws.
    wr(2'd0, 32'h0);
    pulse_src(4'b1000);
    idle(3);
    check("masked_irr", irr, 0);
    rd_check("masked_pend", 2'd2, 'h10);
    wr(2'd0, 32'h10);
    tick();
    check("unmask_irr", irr, 1);
    check("unmask_cause", cause, 4);
    wr(2'd2, 32'h10);
    tick();
    check("w1c_irr", irr, 0);

    // Set beats W1C on the same bit; held level gives one event.
    src_req = 4'b0001;
    wr(2'd2, 32'h02);
    rd_check("set_wins", 2'd2, 'h02);
    wr(2'd2, 32'h1F);
    idle(20);
    rd_check("held_level", 2'd2, 0);
    src_req = '0;
    tick();

    // Reset while in service.
    wr(2'd0, 32'h1F);
    pulse_src(4'b0001);
    tick();
    icall_ack = 1'b1; tick(); icall_ack = 1'b0;
    check("pre_reset_ins", in_service, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("post_reset_ins", in_service, 0);
    check("post_reset_irr", irr, 0);
    rd_check("post_reset_mask", 2'd0, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NSRC; b++)
        if ($urandom_range(7) == 0) src_req[b] = ~src_req[b];
      cfg_we   = ($urandom_range(9) == 0);
      cfg_addr = 2'($urandom_range(3));
      case (cfg_addr)
        2'd1:    cfg_wdata = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
        2'd3:    cfg_wdata = 32'($urandom_range(1));
        default: cfg_wdata = $urandom;
      endcase
      icall_ack = (m_irr != 0 && $urandom_range(2) == 0) || ($urandom_range(19) == 0);
      iret      = (m_ins != 0 && $urandom_range(5) == 0) || ($urandom_range(29) == 0);
      reset     = ($urandom_range(499) == 0);
      tick();
    end
    reset = 1'b0; cfg_we = 1'b0; icall_ack = 1'b0; iret = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
